// File: rtl/adv_counter_pkg.sv
// Shared types and constants for the BCD counter chain: FSM state encoding,
// largest BCD digit value and active-high 7-segment patterns {g,f,e,d,c,b,a}.
package adv_counter_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ADD  = 2'd1,
      SAT  = 2'd2
   } state_t;

   localparam logic [3:0] BCD_MAX = 4'd9;

   localparam logic [6:0] SEG_0     = 7'h3F;
   localparam logic [6:0] SEG_1     = 7'h06;
   localparam logic [6:0] SEG_2     = 7'h5B;
   localparam logic [6:0] SEG_3     = 7'h4F;
   localparam logic [6:0] SEG_4     = 7'h66;
   localparam logic [6:0] SEG_5     = 7'h6D;
   localparam logic [6:0] SEG_6     = 7'h7D;
   localparam logic [6:0] SEG_7     = 7'h07;
   localparam logic [6:0] SEG_8     = 7'h7F;
   localparam logic [6:0] SEG_9     = 7'h6F;
   localparam logic [6:0] SEG_BLANK = 7'h00;

endpackage

// File: rtl/bcd_to_seg7.sv
// Combinational BCD to 7-segment decoder; non-decimal codes 10-15 are blanked.
module bcd_to_seg7
   import adv_counter_pkg::*;
(
   input  logic [3:0] bcd,
   output logic [6:0] seg
);

   // map one BCD code to its segment pattern
   always_comb begin
      seg = SEG_BLANK;
      case (bcd)
         4'd0:    seg = SEG_0;
         4'd1:    seg = SEG_1;
         4'd2:    seg = SEG_2;
         4'd3:    seg = SEG_3;
         4'd4:    seg = SEG_4;
         4'd5:    seg = SEG_5;
         4'd6:    seg = SEG_6;
         4'd7:    seg = SEG_7;
         4'd8:    seg = SEG_8;
         4'd9:    seg = SEG_9;
         default: seg = SEG_BLANK;
      endcase
   end

endmodule

// File: rtl/bcd_counter_chain.sv
// Multi-digit BCD counter fed by the trigger stage. Each increment pulse adds
// a per-digit mask, rippling the carry one digit per clock; refresh pulses
// snapshot the count into a display register that is scanned out as
// multiplexed 7-segment digits.
// Optional feature macro: COUNTER_SATURATE_EN (clamp at all-9s on overflow
// instead of wrapping).
module bcd_counter_chain
   import adv_counter_pkg::*;
#(
   parameter int DIGITS   = 6,
   parameter int SCAN_DIV = 1024
)(
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  inc_pulse,
   input  logic                  ref_pulse,
   input  logic [DIGITS-1:0]     trigger,
   input  logic                  clear,
   output logic                  busy,
   output logic                  overflow,
   output logic [4*DIGITS-1:0]   display_bcd,
   output logic [6:0]            seg,
   output logic [DIGITS-1:0]     digit_en
);

   localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam int SW = $clog2(SCAN_DIV);
   localparam logic [IW-1:0] LAST_IDX  = IW'(DIGITS - 1);
   localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);

   state_t                  state;
   logic [DIGITS-1:0][3:0]  count;
   logic [DIGITS-1:0]       mask;
   logic [IW-1:0]           idx;
   logic                    carry;
   logic                    pend;
   logic [4:0]              sum;
   logic                    sum_carry;
   logic [SW-1:0]           scan_cnt;
   logic                    scan_wrap;
   logic [DIGITS-1:0]       en_nxt;
   logic [3:0]              dsel;
   logic [6:0]              seg_nxt;

   assign busy = (state != IDLE);

   // digit adder for the digit currently addressed by the ripple index
   always_comb begin
      sum       = {1'b0, count[idx]} + {4'b0, mask[idx]} + {4'b0, carry};
      sum_carry = (sum > {1'b0, BCD_MAX});
   end

   // count FSM: latch mask, ripple one digit per cycle, flag/handle overflow
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state    <= IDLE;
         count    <= '0;
         mask     <= '0;
         idx      <= '0;
         carry    <= 1'b0;
         overflow <= 1'b0;
      end else if (clear) begin
         state    <= IDLE;
         count    <= '0;
         idx      <= '0;
         carry    <= 1'b0;
         overflow <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (inc_pulse) begin
                  mask  <= trigger;
                  idx   <= '0;
                  carry <= 1'b0;
                  state <= ADD;
               end
            end
            ADD: begin
               count[idx] <= sum_carry ? 4'(sum - 5'd10) : sum[3:0];
               carry      <= sum_carry;
               idx        <= idx + IW'(1);
               if (idx == LAST_IDX) begin
                  state <= IDLE;
                  if (sum_carry) begin
                     overflow <= 1'b1;
`ifdef COUNTER_SATURATE_EN
                     state    <= SAT;
`endif
                  end
               end
            end
`ifdef COUNTER_SATURATE_EN
            SAT: begin
               count <= {DIGITS{BCD_MAX}};
               state <= IDLE;
            end
`endif
            default: state <= IDLE;
         endcase
      end
   end

   // display snapshot; a refresh seen while busy is deferred to the first idle cycle
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         display_bcd <= '0;
         pend        <= 1'b0;
      end else begin
         if (state == IDLE && (ref_pulse || pend)) begin
            display_bcd <= count;
            pend        <= 1'b0;
         end else if (ref_pulse) begin
            pend <= 1'b1;
         end
         if (clear)
            pend <= 1'b0;
      end
   end

   // next digit select; the mux uses it so seg and digit_en switch together
   always_comb begin
      scan_wrap = (scan_cnt == SCAN_LAST);
      en_nxt    = scan_wrap ? ((digit_en << 1) | (digit_en >> (DIGITS - 1))) : digit_en;
      dsel      = '0;
      for (int i = 0; i < DIGITS; i++)
         if (en_nxt[i])
            dsel = dsel | display_bcd[4*i +: 4];
   end

   bcd_to_seg7 u_dec (
      .bcd (dsel),
      .seg (seg_nxt)
   );

   // free-running scan divider with registered digit select and segments
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         scan_cnt <= '0;
         digit_en <= DIGITS'(1);
         seg      <= SEG_0;
      end else begin
         scan_cnt <= scan_wrap ? '0 : scan_cnt + SW'(1);
         digit_en <= en_nxt;
         seg      <= seg_nxt;
      end
   end

endmodule

// File: tb/tb_bcd_counter_chain.sv
// Self-checking bench for bcd_counter_chain: integer-valued reference model
// compared every cycle, plus directed vectors with literal expectations.
module tb_bcd_counter_chain;

   localparam int DIGITS   = 6;
   localparam int SCAN_DIV = 4;
`ifdef COUNTER_SATURATE_EN
   localparam bit SATM = 1'b1;
`else
   localparam bit SATM = 1'b0;
`endif

   logic                clk = 1'b0;
   logic                rst_n = 1'b0;
   logic                inc_pulse = 1'b0;
   logic                ref_pulse = 1'b0;
   logic [DIGITS-1:0]   trigger = '0;
   logic                clear = 1'b0;
   logic                busy;
   logic                overflow;
   logic [4*DIGITS-1:0] display_bcd;
   logic [6:0]          seg;
   logic [DIGITS-1:0]   digit_en;

   bcd_counter_chain #(.DIGITS(DIGITS), .SCAN_DIV(SCAN_DIV)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .inc_pulse   (inc_pulse),
      .ref_pulse   (ref_pulse),
      .trigger     (trigger),
      .clear       (clear),
      .busy        (busy),
      .overflow    (overflow),
      .display_bcd (display_bcd),
      .seg         (seg),
      .digit_en    (digit_en)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   logic [6:0] SEG_TBL [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int pow10(input int k);
      int r = 1;
      for (int i = 0; i < k; i++) r = r * 10;
      return r;
   endfunction

   function automatic logic [4*DIGITS-1:0] to_bcd(input int v);
      logic [4*DIGITS-1:0] r = '0;
      for (int i = 0; i < DIGITS; i++)
         r[4*i +: 4] = 4'((v / pow10(i)) % 10);
      return r;
   endfunction

   // reference model: count as an integer, busy as a remaining-cycle counter
   int         m_count, m_disp, m_busy, m_new, m_ovf_at, m_scan, m_sel;
   bit         m_ovf, m_new_ovf, m_pend, m_started;
   logic [6:0] m_seg;

   always @(posedge clk) begin : model
      int  nxt_scan, nxt_sel, add, tgt, maxv;
      bit  idle;
      maxv = pow10(DIGITS) - 1;
      m_started <= 1'b1;
      if (!rst_n) begin
         m_count <= 0; m_disp <= 0; m_busy <= 0; m_ovf <= 1'b0; m_pend <= 1'b0;
         m_scan  <= 0; m_sel  <= 0; m_seg  <= 7'h3F;
      end else begin
         idle     = (m_busy == 0);
         nxt_scan = (m_scan == SCAN_DIV - 1) ? 0 : m_scan + 1;
         nxt_sel  = (m_scan == SCAN_DIV - 1) ? (m_sel + 1) % DIGITS : m_sel;
         m_scan  <= nxt_scan;
         m_sel   <= nxt_sel;
         m_seg   <= SEG_TBL[(m_disp / pow10(nxt_sel)) % 10];
         if (idle && (ref_pulse || m_pend)) begin
            m_disp <= m_count;
            m_pend <= 1'b0;
         end else if (ref_pulse) begin
            m_pend <= 1'b1;
         end
         if (clear) begin
            m_pend <= 1'b0; m_count <= 0; m_ovf <= 1'b0; m_busy <= 0;
         end else if (!idle) begin
            m_busy <= m_busy - 1;
            if (m_new_ovf && (m_busy - 1 == m_ovf_at)) m_ovf <= 1'b1;
            if (m_busy == 1) m_count <= m_new;
         end else if (inc_pulse) begin
            add = 0;
            for (int i = 0; i < DIGITS; i++) if (trigger[i]) add += pow10(i);
            tgt = m_count + add;
            if (tgt > maxv) begin
               m_new_ovf <= 1'b1;
               m_new     <= SATM ? maxv : tgt - maxv - 1;
               m_busy    <= SATM ? DIGITS + 1 : DIGITS;
               m_ovf_at  <= SATM ? 1 : 0;
            end else begin
               m_new_ovf <= 1'b0;
               m_new     <= tgt;
               m_busy    <= DIGITS;
               m_ovf_at  <= 0;
            end
         end
      end
   end

   // per-cycle comparison against the model, away from the active edge
   always @(negedge clk) begin
      if (m_started) begin
         chk("busy",     32'(busy),        32'(m_busy > 0));
         chk("overflow", 32'(overflow),    32'(m_ovf));
         chk("display",  32'(display_bcd), 32'(to_bcd(m_disp)));
         chk("digit_en", 32'(digit_en),    32'(1 << m_sel));
         chk("seg",      32'(seg),         32'(m_seg));
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic do_inc(input logic [DIGITS-1:0] m);
      inc_pulse = 1'b1; trigger = m;
      tick(1);
      inc_pulse = 1'b0; trigger = '0;
      tick(19);
   endtask

   task automatic do_ref();
      ref_pulse = 1'b1; tick(1); ref_pulse = 1'b0;
   endtask

   task automatic do_clear();
      clear = 1'b1; tick(1); clear = 1'b0;
   endtask

   task automatic busy_len(input logic [DIGITS-1:0] m, output int n);
      inc_pulse = 1'b1; trigger = m;
      tick(1);
      inc_pulse = 1'b0; trigger = '0;
      n = 0;
      repeat (20) begin
         @(negedge clk);
         if (busy) n++;
      end
      @(posedge clk); #1;
   endtask

   logic [6:0] scan_exp [6] = '{7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06};

   initial begin
      int n, w;
      // reset
      rst_n = 1'b0; tick(3);
      chk("rst_busy", 32'(busy), 32'h0);
      chk("rst_ovf",  32'(overflow), 32'h0);
      chk("rst_disp", 32'(display_bcd), 32'h0);
      chk("rst_en",   32'(digit_en), 32'h01);
      chk("rst_seg",  32'(seg), 32'h3F);
      rst_n = 1'b1; tick(2);

      // single increment: busy length and snapshot
      busy_len(6'b000001, n);
      chk("busy_len_1", 32'(n), 32'd6);
      do_ref();
      chk("inc1_disp", 32'(display_bcd), 32'h000001);
      chk("inc1_ovf",  32'(overflow), 32'h0);

      // 000999 + 1 ripples into the thousands digit
      do_clear();
      repeat (9) do_inc(6'b000111);
      do_inc(6'b000001);
      do_ref();
      chk("carry_1000", 32'(display_bcd), 32'h001000);

      // all-ones mask, then up to all-9s
      do_clear();
      do_inc(6'b111111);
      do_ref();
      chk("all_ones", 32'(display_bcd), 32'h111111);
      repeat (8) do_inc(6'b111111);
      do_ref();
      chk("all_nines", 32'(display_bcd), 32'h999999);
      chk("nines_ovf", 32'(overflow), 32'h0);

      // overflow from 999999
      busy_len(6'b000001, n);
      do_ref();
      chk("ovf_set", 32'(overflow), 32'h1);
`ifdef COUNTER_SATURATE_EN
      chk("ovf_busy_len", 32'(n), 32'd7);
      chk("ovf_sat", 32'(display_bcd), 32'h999999);
      do_inc(6'b000001);
      do_ref();
      chk("sat_hold", 32'(display_bcd), 32'h999999);
`else
      chk("ovf_busy_len", 32'(n), 32'd6);
      chk("ovf_wrap", 32'(display_bcd), 32'h000000);
`endif

      // clear resets overflow but leaves the display alone
      do_clear();
      chk("clr_ovf", 32'(overflow), 32'h0);
`ifdef COUNTER_SATURATE_EN
      chk("clr_disp_kept", 32'(display_bcd), 32'h999999);
`else
      chk("clr_disp_kept", 32'(display_bcd), 32'h000000);
`endif

      // refresh during busy window, second inc ignored
      inc_pulse = 1'b1; trigger = 6'b000001; tick(1);        // edge T
      inc_pulse = 1'b0; trigger = '0; tick(2);               // T+1, T+2
      ref_pulse = 1'b1; tick(1); ref_pulse = 1'b0;           // T+3
      inc_pulse = 1'b1; trigger = 6'b000010; tick(1);        // T+4
      inc_pulse = 1'b0; trigger = '0; tick(2);               // T+5, T+6
`ifdef COUNTER_SATURATE_EN
      chk("pend_not_yet", 32'(display_bcd), 32'h999999);
`else
      chk("pend_not_yet", 32'(display_bcd), 32'h000000);
`endif
      tick(1);                                               // T+7
      chk("pend_snap", 32'(display_bcd), 32'h000001);
      tick(20);
      do_ref();
      chk("inc_ignored", 32'(display_bcd), 32'h000001);

      // clear mid-ADD
      inc_pulse = 1'b1; trigger = 6'b000011; tick(1);
      inc_pulse = 1'b0; trigger = '0; tick(1);
      clear = 1'b1; tick(1); clear = 1'b0;
      chk("midclr_busy", 32'(busy), 32'h0);
      chk("midclr_ovf",  32'(overflow), 32'h0);
      tick(20);
      do_ref();
      chk("midclr_cnt", 32'(display_bcd), 32'h000000);

      // reset mid-ADD
      do_inc(6'b000001);
      do_ref();
      chk("prerst_disp", 32'(display_bcd), 32'h000001);
      inc_pulse = 1'b1; trigger = 6'b000001; tick(1);
      inc_pulse = 1'b0; trigger = '0; tick(2);
      rst_n = 1'b0; tick(1);
      chk("midrst_busy", 32'(busy), 32'h0);
      chk("midrst_ovf",  32'(overflow), 32'h0);
      chk("midrst_disp", 32'(display_bcd), 32'h0);
      chk("midrst_en",   32'(digit_en), 32'h01);
      chk("midrst_seg",  32'(seg), 32'h3F);
      rst_n = 1'b1; tick(2);

      // scan of 123456
      do_inc(6'b111111);
      do_inc(6'b011111);
      do_inc(6'b001111);
      do_inc(6'b000111);
      do_inc(6'b000011);
      do_inc(6'b000001);
      do_ref();
      chk("scan_disp", 32'(display_bcd), 32'h123456);
      tick(2);
      w = 0;
      while (!digit_en[DIGITS-1] && w < 40) begin @(negedge clk); w++; end
      while (digit_en != 6'b000001 && w < 80) begin @(negedge clk); w++; end
      chk("scan_sync", 32'(w < 80), 32'h1);
      for (int k = 0; k < DIGITS; k++) begin
         repeat (SCAN_DIV) begin
            chk("scan_en",  32'(digit_en), 32'(1 << k));
            chk("scan_seg", 32'(seg), 32'(scan_exp[k]));
            @(negedge clk);
         end
      end
      @(posedge clk); #1;

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/bcd_counter_chain.md
# bcd_counter_chain

Receiving end of the trigger-pulse interface. Accepts the increment pulse and the refresh pulse produced by the input debounce/trigger stage. On each increment pulse it adds the sampled per-digit trigger mask to a multi-digit BCD count, rippling carries one digit per cycle within the sender's 16-cycle calculation window. On each refresh pulse it snapshots the count into a display register, which it scans out as multiplexed 7-segment digits.

## Interface
- `DIGITS`, 6: number of BCD digits; digit i has weight 10^i; legal range 1..15.
- `SCAN_DIV`, 1024: clock cycles per display digit slot; must be ≥ 2.
- `clk` in 1: system clock, single clock domain.
- `rst_n` in 1: reset, synchronous, active-low.
- `inc_pulse` in 1: one-cycle increment strobe from the trigger stage.
- `ref_pulse` in 1: one-cycle refresh strobe from the trigger stage.
- `trigger` in DIGITS: per-digit add mask; sampled only in the `inc_pulse` cycle.
- `clear` in 1: synchronous count clear, level-sensitive.
- `busy` out 1: carry ripple in progress.
- `overflow` out 1: sticky; the count has exceeded all-9s since the last reset or clear.
- `display_bcd` out 4*DIGITS: snapshot register; digit i is in bits [4i+3:4i].
- `seg` out 7: active-high segments {g,f,e,d,c,b,a} for the currently selected digit.
- `digit_en` out DIGITS: one-hot active-high digit select.

## Operation
- Reset values (`rst_n`=0 at a clock edge): count 0, `display_bcd` 0, `busy` 0, `overflow` 0, `digit_en` = 1 (digit 0), `seg` = pattern for '0' (7'h3F), scan counter 0, refresh-pending flag 0, state IDLE.
- State machine has three states: IDLE, ADD, SAT.
- IDLE:
  - `inc_pulse`=1: latch `trigger` into the mask, idx←0, carry←0, go to ADD.
  - An all-zero mask still runs the full ADD sequence.
- ADD, one digit per cycle:
  - s = digit[idx] + mask[idx] + carry.
  - s ≥ 10: digit←s−10 and carry←1. Otherwise: digit←s and carry←0.
  - idx←idx+1.
  - After processing idx = DIGITS−1: final carry = 0 goes to IDLE. Final carry = 1 sets `overflow`, then wraps (digits already hold wrapped values) and goes to IDLE. SAT applies instead when enabled.
- SAT: all digits←9, go to IDLE.
- `inc_pulse` outside IDLE: ignored. No queueing and no flag. The sender guarantees a spacing of ≥ 17 cycles.
- Refresh:
  - `ref_pulse` in IDLE (and not the SAT-exit cycle): `display_bcd`←count on the same edge.
  - `ref_pulse` while `busy`: set the pending flag. The snapshot is taken in the first IDLE cycle, then the flag clears.
- `clear`:
  - Priority over `inc_pulse` and over ADD/SAT.
  - Effect: count←0, `overflow`←0, state←IDLE, pending flag←0.
  - `display_bcd` is untouched until the next refresh.
- `rst_n` has priority over everything. Asserting it mid-ADD abandons the operation with all values at reset.
- Scan:
  - Free-running counter 0..SCAN_DIV−1.
  - On wrap, `digit_en` rotates left, from bit DIGITS−1 back to bit 0.
  - `seg` decodes the selected `display_bcd` digit. Codes 10–15 decode to blank (0).

## Timing
- `inc_pulse` at edge T:
  - `busy`=1 for cycles T+1..T+DIGITS.
  - Final count is visible at T+DIGITS+1 (T+DIGITS+2 with SAT).
  - `overflow` rises on the same edge as the final digit update.
- Worst case busy is DIGITS+1 ≤ 16 cycles, which fits inside the sender's refresh delay.
- `display_bcd` updates on the edge that samples `ref_pulse` (IDLE), or on the edge after `busy` falls (pending).
- `seg` and `digit_en` are registered. `seg` follows a `display_bcd` change by 1 cycle.

## Configuration
- `COUNTER_SATURATE_EN` defined: a final carry sets `overflow` and enters SAT, so the count clamps at all-9s and further increments keep it there.
- Undefined: the count wraps modulo 10^DIGITS, `overflow` is still set, and there is no SAT state.

## Structure
- Shared package `adv_counter_pkg` holds:
  - the state enum {IDLE, ADD, SAT};
  - `BCD_MAX` = 4'd9;
  - the 7-segment constants for 0–9 and blank.
- Sub-module `bcd_to_seg7`: 4-bit BCD in, 7-bit segment out, purely combinational. It is instantiated once, on the scan mux output.

## Test plan
- Reset, then `inc_pulse` with `trigger`=6'b000001, then `ref_pulse` 17 cycles later. Required: `busy` high exactly 6 cycles, `display_bcd`=24'h000001, `overflow`=0.
- Count preloaded to 000999 via increments, then inc with `trigger`=6'b000001. Required: count 001000 at T+7.
- Inc with `trigger`=6'b111111 from 0. Required: 111111.
- Repeat the same increment 9 times from 0. Required: 999999.
- From 999999, inc with `trigger`=6'b000001:
  - without the macro: 000000, `overflow`=1;
  - with `COUNTER_SATURATE_EN`: 999999, `overflow`=1, `busy` 7 cycles.
- `ref_pulse` during the busy window (T+3). Required: `display_bcd` updates at T+7 with the final value. A second `inc_pulse` at T+4 is ignored.
- `clear` asserted at T+2 mid-ADD. Required: count 0, `overflow`=0, `busy`=0 next cycle.
- `rst_n` low mid-ADD. Required: all outputs at reset values.
- Scan with `SCAN_DIV`=4, `display_bcd`=24'h123456. Required: `digit_en` steps 000001→000010 every 4 cycles and `seg` shows 6,5,4,3,2,1 (7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06).
